// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and width.
package serial_adder_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fa.sv
// Single-bit full adder cell; combinational sum and carry-out.
module fa (
    output logic sum,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder around one fa cell, LSB first, registered result with done pulse.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             fa_sum, fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    fa u_fa (
        .sum  (fa_sum),
        .cout (fa_cout),
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .cin  (carry_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = cin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                // Final bit goes straight into the result so sum never shows a partial value.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {fa_sum, acc_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ fa_cout;
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed vectors plus exhaustive WIDTH=2 sweep.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, busy2, done2, cout2, ovf2;
    logic [1:0] a2, b2, sum2;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .cin   (cin2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .cout  (cout2)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf2)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf8 = 1'b0;
    assign ovf2 = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t q8[$];
    exp_t q2[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: pops on done, otherwise requires the held result to stay put.
    exp_t held8 = '0;
    exp_t held2 = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held8 = '0;
            held2 = '0;
        end else begin
            if (done8) begin
                if (q8.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done8: got done=1 expected no completion at %0t", $time);
                end else begin
                    e = q8.pop_front();
                    check("sum8", 32'(sum8), 32'(e.sum));
                    check("cout8", 32'(cout8), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
                    check("ovf8", 32'(ovf8), 32'(e.ovf));
`endif
                    held8 = e;
                end
            end else begin
                check("hold8", {23'd0, sum8, cout8}, {23'd0, held8.sum, held8.cout});
            end
            if (done2) begin
                if (q2.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done2: got done=1 expected no completion at %0t", $time);
                end else begin
                    e = q2.pop_front();
                    check("sum2", 32'(sum2), 32'(e.sum));
                    check("cout2", 32'(cout2), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
                    check("ovf2", 32'(ovf2), 32'(e.ovf));
`endif
                    held2 = e;
                end
            end else begin
                check("hold2", {29'd0, sum2, cout2}, {29'd0, held2.sum[1:0], held2.cout});
            end
        end
    end

    task automatic wait_done8(output int lat);
        lat = 0;
        while (!done8 && lat < 50) begin
            @(posedge clk);
            lat++;
            #1;
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        q8.push_back('{sum: es, cout: ec, ovf: eo});
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = ~a; b8 = ~b; cin8 = ~c;
        wait_done8(lat);
        check("latency8", 32'(lat), 32'd8);
        @(posedge clk);
        #1;
        check("idle_after_done8", 32'(busy8), 32'd0);
    endtask

    task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic c,
                        input logic [1:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        a2 = a; b2 = b; cin2 = c; start2 = 1'b1;
        q2.push_back('{sum: {6'd0, es}, cout: ec, ovf: eo});
        @(posedge clk);
        #1;
        start2 = 1'b0;
        a2 = ~a; b2 = ~b;
        lat = 0;
        while (!done2 && lat < 50) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("latency2", 32'(lat), 32'd2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_sum8", {23'd0, sum8, cout8, ovf8}, 32'd0);
        check("rst_out2", {25'd0, busy2, done2, sum2, cout2, ovf2}, 32'd0);
        rst = 1'b0;

        // Basic and carry-boundary vectors: a, b, cin -> sum, cout, ovf
        run8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Restart attempts while busy in SHIFT and in DONE must be ignored.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back('{sum: 8'h46, cout: 1'b0, ovf: 1'b0});
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a8 = 8'hF0; b8 = 8'hF0; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        wait_done8(lat);
        check("latency8_restart", 32'(lat), 32'd5);
        a8 = 8'hF0; b8 = 8'hF0; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        check("ignore_start_in_done", 32'(busy8), 32'd0);
        @(posedge clk);
        #1;
        check("still_idle", 32'(busy8), 32'd0);

        // Asynchronous reset in the 4th SHIFT cycle discards the add and clears outputs.
        @(negedge clk);
        a8 = 8'hC3; b8 = 8'h11; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_busy8", 32'(busy8), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy8", 32'(busy8), 32'd0);
        check("mid_rst_done8", 32'(done8), 32'd0);
        check("mid_rst_sum8", {23'd0, sum8, cout8, ovf8}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        run8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        // Exhaustive WIDTH=2 sweep against an arithmetic model.
        for (int i = 0; i < 32; i++) begin
            logic [1:0] ta, tb;
            logic       tc, eo;
            logic [2:0] tot;
            ta  = 2'(i >> 3);
            tb  = 2'(i >> 1);
            tc  = i[0];
            tot = 3'(ta) + 3'(tb) + 3'(tc);
            eo  = ta[1] ^ tb[1] ^ tot[1] ^ tot[2];
            run2(ta, tb, tc, tot[1:0], tot[2], eo);
        end

        repeat (3) @(posedge clk);
        #1;
        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
